ksa_wide_seq: RTL and testbench

//  Multi-cycle wide add/subtract sequencer built around one 16-bit kogge_stone adder.

---
 rtl/ksa_wide_seq.sv | 163 ++++++++++++++++
 tb/tb_ksa_wide_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ksa_wide_seq.sv
// Multi-cycle wide add/sub: one 16-bit Kogge-Stone adder, one chunk per cycle.
// Ports: clk, rst (async high); in_valid/in_ready, op_sub, a, b, cin in;
// out_valid/out_ready, sum, cout, ovf out. KSA_SEQ_OVF_EN enables ovf.
module ksa_wide_seq #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  op_sub,
  input  logic [16*WORDS-1:0]   a,
  input  logic [16*WORDS-1:0]   b,
  input  logic                  cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*WORDS-1:0]   sum,
  output logic                  cout,
  output logic                  ovf
);

  localparam int W  = 16 * WORDS;
  localparam int IW = $clog2(WORDS + 1);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          carry_q, carry_d;
  logic          cout_q, cout_d;

  logic [15:0]   a_ch, b_ch, ks_s;
  logic          ks_co, last;

  // Chunk select as a compare mux so idx width never mismatches the index
  always_comb begin
    a_ch = '0;
    b_ch = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (idx_q == IW'(k)) begin
        a_ch = a_q[16*k +: 16];
        b_ch = b_q[16*k +: 16];
      end
    end
  end

  // 16-bit Kogge-Stone: 4 prefix levels, carry-in folded in at the end
  logic [4:0][15:0] kg, kp;
  logic [15:0]      kc;

  assign kg[0] = a_ch & b_ch;
  assign kp[0] = a_ch ^ b_ch;

  for (genvar l = 0; l < 4; l++) begin : g_lvl
    for (genvar i = 0; i < 16; i++) begin : g_bit
      if (i >= (1 << l)) begin : g_op
        assign kg[l+1][i] = kg[l][i] |
                            (kp[l][i] & kg[l][i-(1<<l)]);
        assign kp[l+1][i] = kp[l][i] & kp[l][i-(1<<l)];
      end else begin : g_pass
        assign kg[l+1][i] = kg[l][i];
        assign kp[l+1][i] = kp[l][i];
      end
    end
  end

  assign kc[0] = carry_q;
  for (genvar i = 1; i < 16; i++) begin : g_c
    assign kc[i] = kg[4][i-1] | (kp[4][i-1] & carry_q);
  end

  assign ks_s  = kp[0] ^ kc;
  assign ks_co = kg[4][15] | (kp[4][15] & carry_q);

  assign last      = (idx_q == LAST);
  assign in_ready  = (state_q == IDLE) & ~rst;
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid & in_ready) begin
          a_d     = a;
          b_d     = op_sub ? ~b : b;
          carry_d = op_sub | cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int k = 0; k < WORDS; k++) begin
          if (idx_q == IW'(k)) sum_d[16*k +: 16] = ks_s;
        end
        carry_d = ks_co;
        if (last) begin
          cout_d  = ks_co;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

`ifdef KSA_SEQ_OVF_EN
  logic ovf_q;

  // b_q is already inverted for subtract, so one rule covers both ops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if ((state_q == RUN) && last) begin
      ovf_q <= (a_q[W-1] == b_q[W-1]) & (ks_s[15] != a_q[W-1]);
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_ksa_wide_seq.sv
// Bench for ksa_wide_seq (WORDS=4): directed cases plus random
// ops with stalls, checked against a plain 65-bit arithmetic model.
module tb_ksa_wide_seq;

  localparam int N_RND = 1000;
  localparam int LIMIT = 60000;
`ifdef KSA_SEQ_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        op_sub;
  logic [63:0] a, b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] sum;
  logic        cout;
  logic        ovf;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  ksa_wide_seq #(.WORDS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {ovf, cout, sum} from plain arithmetic
  function automatic logic [65:0] ref_op(input logic s,
                                         input logic [63:0] x,
                                         input logic [63:0] y,
                                         input logic c);
    logic [64:0] r;
    logic        o;
    if (s) begin
      r[63:0] = x - y;
      r[64]   = (x >= y);
      o = (x[63] != y[63]) && (r[63] != x[63]);
    end else begin
      r = {1'b0, x} + {1'b0, y} + {64'd0, c};
      o = (x[63] == y[63]) && (r[63] != x[63]);
    end
    return {o & OVF_ON, r};
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic run_op(input logic s,
                        input logic [63:0] x,
                        input logic [63:0] y,
                        input logic c,
                        input int hold,
                        output logic [65:0] res,
                        output int lat);
    int n;
    logic [63:0] s0;
    @(negedge clk);
    op_sub = s; a = x; b = y; cin = c;
    in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = rnd64(); b = rnd64();
    op_sub = $urandom_range(0, 1) == 1;
    cin = $urandom_range(0, 1) == 1;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    s0 = sum;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      chk("hold_rdy", in_ready, 0);
      chk("hold_vld", out_valid, 1);
      chk("hold_sum", sum, s0);
    end
    @(negedge clk);
    res = {ovf, cout, sum};
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  logic [65:0] exp_q[$];
  int sent, got;

  initial begin
    logic [65:0] r;
    int lat;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op_sub = 1'b0; a = '0; b = '0; cin = 1'b0;
    #12;
    chk("rst_rdy", in_ready, 0);
    chk("rst_vld", out_valid, 0);
    chk("rst_sum", {ovf, cout, sum}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_rdy", in_ready, 1);

    run_op(0, '1, 64'd1, 0, 0, r, lat);
    chk("t1_res", r, {1'b0, 1'b1, 64'd0});
    chk("t1_lat", lat, 4);

    run_op(1, 64'd5, 64'd7, 1, 0, r, lat);
    chk("t2a_res", r[64:0], {1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
    chk("t2a_ref", r, ref_op(1, 64'd5, 64'd7, 1));
    run_op(1, 64'd7, 64'd5, 0, 0, r, lat);
    chk("t2b_res", r[64:0], {1'b1, 64'd2});

    run_op(0, 64'h0000_FFFF_0000_FFFF, 64'd1, 1, 10, r, lat);
    chk("t3_res", r[64:0], {1'b0, 64'h0000_FFFF_0001_0001});
    repeat (6) @(posedge clk);
    #1;
    chk("t3_nodup", out_valid, 0);

    @(negedge clk);
    op_sub = 1'b0; a = rnd64(); b = rnd64(); cin = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t4_vld", out_valid, 0);
    chk("t4_sum", {ovf, cout, sum}, 0);
    chk("t4_rdy", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t4_rel", in_ready, 1);
    run_op(0, 64'd3, 64'd4, 0, 0, r, lat);
    chk("t4_res", r[64:0], {1'b0, 64'd7});
    chk("t4_lat", lat, 4);

    run_op(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, r, lat);
    chk("t5_res", r, {OVF_ON, 1'b0, 64'h8000_0000_0000_0000});
    run_op(1, 64'h8000_0000_0000_0000, 64'd1, 0, 0, r, lat);
    chk("t5_sub", r, {OVF_ON, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF});

    sent = 0;
    got  = 0;
    fork
      begin : producer
        logic fire;
        logic [63:0] x, y;
        while (sent < N_RND && cyc < LIMIT) begin
          @(negedge clk);
          fire = 1'b0;
          if (!in_valid && $urandom_range(0, 3) != 0) begin
            x = ($urandom_range(0, 7) == 0) ? '1 : rnd64();
            y = ($urandom_range(0, 7) == 0) ? '0 : rnd64();
            a = x; b = y;
            op_sub = $urandom_range(0, 1) == 1;
            cin = $urandom_range(0, 1) == 1;
            in_valid = 1'b1;
          end
          if (in_valid && in_ready) begin
            exp_q.push_back(ref_op(op_sub, a, b, cin));
            sent++;
            fire = 1'b1;
          end
          @(posedge clk);
          #1;
          if (fire) in_valid = 1'b0;
        end
        in_valid = 1'b0;
      end
      begin : consumer
        logic [65:0] e;
        while (got < N_RND && cyc < LIMIT) begin
          @(negedge clk);
          out_ready = $urandom_range(0, 2) != 0;
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              chk("rnd_extra", 1, 0);
            end else begin
              e = exp_q.pop_front();
              chk("rnd_res", {ovf, cout, sum}, e);
            end
            got++;
          end
        end
        out_ready = 1'b0;
      end
    join
    chk("rnd_count", got, N_RND);
    chk("rnd_left", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
